branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Fetch-steering controller that sequences redirects of the program counter. It records every branch prediction issued at fetch in an in-order queue and checks each one against the execute-stage resolution. On a mismatch it issues a one-cycle registered flush with the corrected fetch address, then holds fetch while the pipeline drains. It also back-pressures fetch when too many predictions are outstanding, and keeps branch/mispredict statistics.

## Interface
- ADDR_WIDTH, 16, instruction-memory address width
- DEPTH, 4, max outstanding predicted branches (power of two, ≥2)
- RECOVER_CYCLES, 2, fetch-hold cycles after a flush (≥1)
- CNT_WIDTH, 16, statistics counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  fetch stalled this cycle
- pc  in  ADDR_WIDTH  address of the fetch pair currently issued
- pred_valid  in  1  fetch issued a conditional branch this cycle
- pred_taken  in  1  predicted direction
- pred_target  in  ADDR_WIDTH  predicted taken target
- resolve_valid  in  1  execute resolved the oldest branch
- resolve_taken  in  1  actual direction
- resolve_target  in  ADDR_WIDTH  actual taken target
- flush  out  1  redirect fetch, kill younger instructions
- flush_address  out  ADDR_WIDTH  corrected fetch address
- fetch_hold  out  1  fetch must not advance
- queue_full  out  1  DEPTH entries outstanding
- underflow  out  1  sticky: resolve arrived with empty queue
- branch_count  out  CNT_WIDTH  resolved branches, saturating
- mispredict_count  out  CNT_WIDTH  mispredicts, saturating

## Operation
- Queue entry: {taken, target, fallthrough = pc + 2}; circular FIFO with wrapping read/write pointers and an occupancy count.
- Push when pred_valid & !stall & !queue_full & state==IDLE & !flush. Pushes in any other cycle are dropped; fetch must honour queue_full.
- Pop head when resolve_valid and the queue is non-empty. branch_count increments, saturating at all-ones.
- Mispredict condition: head.taken != resolve_taken, or both taken and head.target != resolve_target.
- On mispredict:
  - Next cycle flush=1 and flush_address = resolve_taken ? resolve_target : head.fallthrough.
  - The whole queue is cleared; the same-cycle push is discarded.
  - mispredict_count increments, saturating.
- Push and a non-mispredicting pop in the same cycle: both happen and occupancy is unchanged; legal even when full.
- resolve_valid with an empty queue: no pop, no flush, underflow set; only reset clears it.
- States:
  - IDLE: accepts pushes and pops.
  - IDLE → RECOVER on mispredict.
  - RECOVER: counter loads RECOVER_CYCLES and decrements each cycle; returns to IDLE when it reaches 1.
  - In RECOVER, pred_valid and resolve_valid are ignored (younger branches are already killed).
- Reset: queue empty, pointers 0, state IDLE; flush, flush_address, fetch_hold, queue_full, underflow and both counters all 0. Reset overrides all other inputs in the same edge.

## Timing
- Resolve at edge N (mispredict): flush and flush_address valid in cycle N+1 only. fetch_hold=1 in cycles N+1 … N+RECOVER_CYCLES.
- flush, flush_address and fetch_hold are registered; no input-to-output combinational paths.
- queue_full is registered from occupancy. It reflects pushes and pops of the previous edge.
- flush_address holds its last value when flush=0.
- Back-to-back resolves every cycle are supported, one pop per cycle.
- Reset asserted during RECOVER aborts recovery: fetch_hold=0 on the following cycle.

## Test plan
- Push taken/0x0040 at pc 0x0010, then resolve taken/0x0040 → no flush, branch_count=1, queue empty.
- Push taken/0x0040 at pc 0x0010, then resolve not-taken → flush=1 one cycle with flush_address=0x0012; fetch_hold for 2 cycles; mispredict_count=1.
- Push 4 predictions → queue_full=1; a 5th push is dropped; a push and a resolve in the same cycle keep occupancy at 4; 4 correct resolves drain the queue and queue_full=0.
- Three queued predictions; the 2nd is resolved with target 0x0100 vs predicted 0x0080 → flush_address=0x0100; queue empty; pred_valid during RECOVER is ignored.
- resolve_valid on empty queue → underflow=1 sticky, no flush; reset clears it.
- Force 0xFFFF mispredicts (or use CNT_WIDTH=4 with 16) → counter saturates at all-ones. Reset mid-RECOVER → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch prediction tracker: in-order queue of fetch predictions checked against execute resolutions.
// Mispredict -> registered flush one cycle later, then fetch held RECOVER_CYCLES; queue_full back-pressures fetch.
module branch_redirect_ctrl #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  pred_valid,
    input  logic                  pred_taken,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  resolve_valid,
    input  logic                  resolve_taken,
    input  logic [ADDR_WIDTH-1:0] resolve_target,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_address,
    output logic                  fetch_hold,
    output logic                  queue_full,
    output logic                  underflow,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int RC_W  = $clog2(RECOVER_CYCLES + 1);
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic                  taken;
        logic [ADDR_WIDTH-1:0] target;
        logic [ADDR_WIDTH-1:0] fallthrough;
    } entry_t;

    typedef enum logic {IDLE, RECOVER} state_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   occ, occ_nxt;
    logic [RC_W-1:0]  rcnt;
    state_t           state, state_nxt;
    logic             idle, pop, push, mismatch, mispredict;

    assign head     = mem[rd_ptr];
    assign idle     = (state == IDLE);
    assign pop      = idle && resolve_valid && (occ != '0);
    assign mismatch = (head.taken != resolve_taken) ||
                      (head.taken && resolve_taken && (head.target != resolve_target));
    assign mispredict = pop && mismatch;
    // A full queue still accepts a push when a correct pop frees the head slot in the same cycle.
    assign push = idle && pred_valid && !stall && !flush && !mispredict &&
                  (!queue_full || pop);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mispredict) state_nxt = RECOVER;
            RECOVER: if (rcnt == RC_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        occ_nxt = occ;
        if (mispredict)
            occ_nxt = '0;
        else if (push && !pop)
            occ_nxt = occ + (PTR_W+1)'(1);
        else if (pop && !push)
            occ_nxt = occ - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{taken: pred_taken, target: pred_target,
                             fallthrough: pc + ADDR_WIDTH'(2)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            rcnt             <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            occ              <= '0;
            flush            <= 1'b0;
            flush_address    <= '0;
            fetch_hold       <= 1'b0;
            queue_full       <= 1'b0;
            underflow        <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            state      <= state_nxt;
            fetch_hold <= (state_nxt == RECOVER);
            flush      <= mispredict;
            occ        <= occ_nxt;
            queue_full <= (occ_nxt == FULL_OCC);

            if (mispredict)
                rcnt <= RC_W'(RECOVER_CYCLES);
            else if (state == RECOVER)
                rcnt <= rcnt - RC_W'(1);

            if (mispredict) begin
                flush_address <= resolve_taken ? resolve_target : head.fallthrough;
                rd_ptr        <= '0;
                wr_ptr        <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (idle && resolve_valid && (occ == '0))
                underflow <= 1'b1;
            if (pop && (branch_count != '1))
                branch_count <= branch_count + CNT_WIDTH'(1);
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; a reference queue model predicts every registered output each cycle.
module tb_branch_redirect_ctrl;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int RC    = 2;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, stall, pred_valid, pred_taken, resolve_valid, resolve_taken;
    logic [AW-1:0] pc, pred_target, resolve_target;
    logic          flush, fetch_hold, queue_full, underflow;
    logic [AW-1:0] flush_address;
    logic [CW-1:0] branch_count, mispredict_count;

    branch_redirect_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RECOVER_CYCLES(RC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .flush(flush), .flush_address(flush_address), .fetch_hold(fetch_hold),
        .queue_full(queue_full), .underflow(underflow),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          taken;
        logic [AW-1:0] target;
        logic [AW-1:0] ft;
    } mentry_t;

    typedef struct packed {
        logic          f;
        logic [AW-1:0] a;
    } exp_t;

    mentry_t       mq[$];
    exp_t          exp_q[$];
    int            m_hold, m_bc, m_mc;
    logic          m_uf;
    logic [AW-1:0] m_addr;
    int            passes = 0;
    int            total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic drive_idle();
        stall = 1'b0; pc = '0; pred_valid = 1'b0; pred_taken = 1'b0; pred_target = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mq.delete(); exp_q.delete();
        m_hold = 0; m_bc = 0; m_mc = 0; m_uf = 1'b0; m_addr = '0;
        check("rst_flush", flush, 0);
        check("rst_flush_address", flush_address, 0);
        check("rst_fetch_hold", fetch_hold, 0);
        check("rst_queue_full", queue_full, 0);
        check("rst_underflow", underflow, 0);
        check("rst_branch_count", branch_count, 0);
        check("rst_mispredict_count", mispredict_count, 0);
    endtask

    // One clock: drive inputs, advance the model, then compare all outputs after the edge.
    task automatic cycle(input logic pv, input logic [AW-1:0] ppc, input logic pt,
                         input logic [AW-1:0] ptg, input logic rv, input logic rt,
                         input logic [AW-1:0] rtg, input logic stl);
        logic    idle, pop, mis, push;
        mentry_t h;
        exp_t    e;
        stall = stl; pc = ppc; pred_valid = pv; pred_taken = pt; pred_target = ptg;
        resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;

        idle = (m_hold == 0);
        pop  = idle && rv && (mq.size() > 0);
        mis  = 1'b0;
        h    = '0;
        if (pop) begin
            h   = mq.pop_front();
            mis = (h.taken != rt) || (rt && (h.target != rtg));
            m_bc = (m_bc == MAXC) ? MAXC : m_bc + 1;
        end
        if (idle && rv && !pop) m_uf = 1'b1;
        push = idle && pv && !stl && !mis && ((mq.size() + (pop ? 1 : 0)) < DEPTH + (pop ? 1 : 0));
        if (mis) begin
            mq.delete();
            m_mc   = (m_mc == MAXC) ? MAXC : m_mc + 1;
            m_addr = rt ? rtg : h.ft;
        end
        if (push) mq.push_back('{taken: pt, target: ptg, ft: ppc + 16'd2});
        e.f = mis; e.a = m_addr;
        exp_q.push_back(e);
        if (mis) m_hold = RC;
        else if (m_hold > 0) m_hold--;

        @(posedge clk); #1;
        drive_idle();
        e = exp_q.pop_front();
        check("flush", flush, e.f);
        check("flush_address", flush_address, e.a);
        check("fetch_hold", fetch_hold, m_hold > 0);
        check("queue_full", queue_full, mq.size() == DEPTH);
        check("underflow", underflow, m_uf);
        check("branch_count", branch_count, m_bc);
        check("mispredict_count", mispredict_count, m_mc);
    endtask

    task automatic push_pred(input logic [AW-1:0] ppc, input logic pt, input logic [AW-1:0] ptg);
        cycle(1'b1, ppc, pt, ptg, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input logic rt, input logic [AW-1:0] rtg);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, rt, rtg, 1'b0);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // correct taken prediction
        push_pred(16'h0010, 1'b1, 16'h0040);
        resolve(1'b1, 16'h0040);
        check("t1_branch_count", branch_count, 1);

        // direction mispredict redirects to the fall-through
        push_pred(16'h0010, 1'b1, 16'h0040);
        resolve(1'b0, 16'h0000);
        check("t2_flush_address", flush_address, 16'h0012);
        idle_cycle();
        idle_cycle();
        check("t2_hold_released", fetch_hold, 0);

        // fill, overflow drop, concurrent push/pop at full, drain
        cycle(1'b1, 16'h00F0, 1'b1, 16'h0300, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) push_pred(16'h0100 + AW'(2 * i), 1'b0, '0);
        check("t3_full", queue_full, 1);
        push_pred(16'h0110, 1'b1, 16'h0700);
        cycle(1'b1, 16'h0120, 1'b1, 16'h0200, 1'b1, 1'b0, '0, 1'b0);
        check("t3_still_full", queue_full, 1);
        for (int i = 0; i < DEPTH - 1; i++) resolve(1'b0, '0);
        resolve(1'b1, 16'h0200);
        check("t3_drained", queue_full, 0);

        // target mispredict on the second entry, pushes ignored while recovering
        push_pred(16'h0020, 1'b0, '0);
        push_pred(16'h0030, 1'b1, 16'h0080);
        push_pred(16'h0040, 1'b0, '0);
        resolve(1'b0, '0);
        resolve(1'b1, 16'h0100);
        check("t4_flush_address", flush_address, 16'h0100);
        push_pred(16'h0050, 1'b1, 16'h0090);
        idle_cycle();

        // empty-queue resolve sets sticky underflow
        resolve(1'b1, 16'h0090);
        check("t5_underflow", underflow, 1);
        idle_cycle();
        do_reset();

        // mispredict counter saturation
        for (int i = 0; i < MAXC + 2; i++) begin
            push_pred(16'h0010, 1'b1, 16'h0040);
            resolve(1'b0, '0);
            idle_cycle();
            idle_cycle();
        end
        check("t6_mispredict_sat", mispredict_count, MAXC);

        // reset during recovery
        do_reset();
        push_pred(16'h0010, 1'b1, 16'h0040);
        resolve(1'b1, 16'h0044);
        check("t7_flush", flush, 1);
        do_reset();
        idle_cycle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
